// File: rtl/clock_display_driver_pkg.sv
// Shared types and constants for the clock display driver.
// Holds FSM/field enums, snapshot/BCD bundles, segment table and helpers.
package clock_disp_pkg;

   localparam int NUM_FIELDS = 6;
   localparam int DD_ITER    = 14;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_STORE,
      S_COMMIT
   } state_e;

   typedef enum logic [2:0] {
      F_SEC,
      F_MIN,
      F_HOUR,
      F_DAY,
      F_MON,
      F_YEAR
   } field_e;

   typedef struct packed {
      logic [13:0] year;
      logic [3:0]  mon;
      logic [4:0]  day;
      logic [4:0]  hour;
      logic [5:0]  min;
      logic [5:0]  sec;
   } snap_t;

   typedef struct packed {
      logic [15:0] year;
      logic [7:0]  mon;
      logic [7:0]  day;
      logic [7:0]  hour;
      logic [7:0]  min;
      logic [7:0]  sec;
   } bcd_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Active-low, bit0 = a .. bit6 = g; entry n is digit n.
   localparam logic [9:0][6:0] SEG_DIGIT = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      if (d > 4'd9) return SEG_BLANK;
      return SEG_DIGIT[d];
   endfunction

   // One double-dabble iteration on {bcd, bin}: adjust, then shift left.
   function automatic logic [29:0] dd_step(
      input logic [15:0] bcd,
      input logic [13:0] bin
   );
      logic [15:0] adj;
      adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      return {adj, bin} << 1;
   endfunction

endpackage

// File: rtl/clock_display_driver_bin2bcd.sv
// Serial 14-bit binary to 4-digit BCD converter (fixed 14 iterations).
// Ports: clk, rst_n, start/bin in; bcd, valid (result held), last (final iteration).
module bin2bcd_serial
   import clock_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [13:0] bin,
   output logic [15:0] bcd,
   output logic        valid,
   output logic        last
);

   logic [13:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        run_q, run_d;
   logic        valid_q, valid_d;
   logic [29:0] step;

   assign step = dd_step(bcd_q, bin_q);

   always_comb begin
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      valid_d = valid_q;
      if (start) begin
         bin_d   = bin;
         bcd_d   = '0;
         cnt_d   = '0;
         run_d   = 1'b1;
         valid_d = 1'b0;
      end else if (run_q) begin
         bcd_d = step[29:14];
         bin_d = step[13:0];
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == 4'(DD_ITER - 1)) begin
            run_d   = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         valid_q <= valid_d;
      end
   end

   assign bcd   = bcd_q;
   assign valid = valid_q;
   // Lets the controller leave SHIFT on the same edge as the final iteration.
   assign last  = run_q && (cnt_q == 4'(DD_ITER - 1));

endmodule

// File: rtl/clock_display_driver.sv
// Captures a time/date snapshot, converts each field to BCD serially and
// drives eight active-low 7-segment digits (time or date view via mode).
module clock_display_driver
   import clock_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample,
   input  logic        mode,
   input  logic [5:0]  sec_bin,
   input  logic [5:0]  min_bin,
   input  logic [4:0]  hour_bin,
   input  logic [4:0]  day_bin,
   input  logic [3:0]  month_bin,
   input  logic [13:0] year_bin,
   output logic        busy,
   output logic        done,
   output logic [6:0]  seg7,
   output logic [6:0]  seg6,
   output logic [6:0]  seg5,
   output logic [6:0]  seg4,
   output logic [6:0]  seg3,
   output logic [6:0]  seg2,
   output logic [6:0]  seg1,
   output logic [6:0]  seg0
);

   state_e state_q, state_d;
   field_e fld_q, fld_d;
   snap_t  snap_q, snap_d;
   bcd_t   wrk_q, wrk_d;
   bcd_t   com_q, com_d;
   logic   ovf_q, ovf_d;
   logic   shown_q, shown_d;
   logic   busy_q, busy_d;
   logic   commit_q, commit_d;
   logic   done_q, done_d;
   logic [7:0][6:0] seg_q, seg_d;

   logic        accept;
   logic        conv_start;
   logic [13:0] conv_bin;
   logic [15:0] conv_bcd;
   logic        conv_valid;
   logic        conv_last;

   bin2bcd_serial u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin   (conv_bin),
      .bcd   (conv_bcd),
      .valid (conv_valid),
      .last  (conv_last)
   );

   assign conv_start = (state_q == S_LOAD);

   always_comb begin
      conv_bin = '0;
      unique case (fld_q)
         F_SEC:   conv_bin = {8'd0, snap_q.sec};
         F_MIN:   conv_bin = {8'd0, snap_q.min};
         F_HOUR:  conv_bin = {9'd0, snap_q.hour};
         F_DAY:   conv_bin = {9'd0, snap_q.day};
         F_MON:   conv_bin = {10'd0, snap_q.mon};
         F_YEAR:  conv_bin = snap_q.year;
         default: conv_bin = '0;
      endcase
   end

   // COMMIT accepts a new sample too, so back-to-back frames lose no cycle.
   assign accept = sample &&
                   (state_q == S_IDLE || state_q == S_COMMIT);

   always_comb begin
      state_d  = state_q;
      fld_d    = fld_q;
      snap_d   = snap_q;
      wrk_d    = wrk_q;
      com_d    = com_q;
      ovf_d    = ovf_q;
      shown_d  = shown_q;
      busy_d   = busy_q;
      commit_d = 1'b0;
      unique case (state_q)
         S_IDLE:  state_d = S_IDLE;
         S_LOAD:  state_d = S_SHIFT;
         S_SHIFT: if (conv_last) state_d = S_STORE;
         S_STORE: begin
            unique case (fld_q)
               F_SEC:   wrk_d.sec  = conv_bcd[7:0];
               F_MIN:   wrk_d.min  = conv_bcd[7:0];
               F_HOUR:  wrk_d.hour = conv_bcd[7:0];
               F_DAY:   wrk_d.day  = conv_bcd[7:0];
               F_MON:   wrk_d.mon  = conv_bcd[7:0];
               F_YEAR:  wrk_d.year = conv_bcd;
               default: wrk_d = wrk_q;
            endcase
            if (fld_q == F_YEAR || !conv_valid) begin
               state_d = S_COMMIT;
            end else begin
               fld_d   = field_e'(fld_q + 3'd1);
               state_d = S_LOAD;
            end
         end
         S_COMMIT: begin
            com_d    = wrk_q;
            ovf_d    = (snap_q.year > 14'd9999);
            shown_d  = 1'b1;
            commit_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         state_d = S_LOAD;
         fld_d   = F_SEC;
         busy_d  = 1'b1;
         snap_d  = '{year: year_bin, mon: month_bin,
                     day: day_bin, hour: hour_bin,
                     min: min_bin, sec: sec_bin};
      end
   end

   assign done_d = commit_q;

   always_comb begin
      seg_d = {8{SEG_BLANK}};
      if (shown_q) begin
         if (!mode) begin
            seg_d[7] = seg_of(com_q.hour[7:4]);
            seg_d[6] = seg_of(com_q.hour[3:0]);
            seg_d[5] = seg_of(com_q.min[7:4]);
            seg_d[4] = seg_of(com_q.min[3:0]);
            seg_d[3] = seg_of(com_q.sec[7:4]);
            seg_d[2] = seg_of(com_q.sec[3:0]);
         end else begin
            seg_d[7] = seg_of(com_q.day[7:4]);
            seg_d[6] = seg_of(com_q.day[3:0]);
            seg_d[5] = seg_of(com_q.mon[7:4]);
            seg_d[4] = seg_of(com_q.mon[3:0]);
            if (ovf_q) begin
               seg_d[3:0] = {4{SEG_DASH}};
            end else begin
               seg_d[3] = seg_of(com_q.year[15:12]);
               seg_d[2] = seg_of(com_q.year[11:8]);
               seg_d[1] = seg_of(com_q.year[7:4]);
               seg_d[0] = seg_of(com_q.year[3:0]);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         fld_q    <= F_SEC;
         snap_q   <= '0;
         wrk_q    <= '0;
         com_q    <= '0;
         ovf_q    <= 1'b0;
         shown_q  <= 1'b0;
         busy_q   <= 1'b0;
         commit_q <= 1'b0;
         done_q   <= 1'b0;
         seg_q    <= {8{SEG_BLANK}};
      end else begin
         state_q  <= state_d;
         fld_q    <= fld_d;
         snap_q   <= snap_d;
         wrk_q    <= wrk_d;
         com_q    <= com_d;
         ovf_q    <= ovf_d;
         shown_q  <= shown_d;
         busy_q   <= busy_d;
         commit_q <= commit_d;
         done_q   <= done_d;
         seg_q    <= seg_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign seg7 = seg_q[7];
   assign seg6 = seg_q[6];
   assign seg5 = seg_q[5];
   assign seg4 = seg_q[4];
   assign seg3 = seg_q[3];
   assign seg2 = seg_q[2];
   assign seg1 = seg_q[1];
   assign seg0 = seg_q[0];

endmodule
